reg_scoreboard: RTL
===================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 16: number of architectural registers tracked.
REQ-002 Parameter REG_ADDR_W, default 4: register address width; SHALL equal clog2(NUM_REGS).
REQ-003 Parameter CNT_W, default 2: per-register pending-write counter width; max pending = 2^CNT_W-1.
REQ-004 Parameter RETIRE_BYPASS, default 1: when 1, a same-cycle retire to a source register clears that source's hazard (write-through register file).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 src1, src2  in  REG_ADDR_W each  source registers of the instruction in decode.
REQ-008 has_src1, has_src2  in  1 each  source is actually read.
REQ-009 issue_valid  in  1  decode instruction presented for issue.
REQ-010 issue_wb_en, issue_dst  in  1, REG_ADDR_W  issuing instruction writes issue_dst.
REQ-011 retire_valid, retire_dst  in  1, REG_ADDR_W  writeback stage commits a write to retire_dst.
REQ-012 kill_valid, kill_dst  in  1, REG_ADDR_W  an issued writer was squashed by a taken branch and will never retire.
REQ-013 hazard_detected  out  1  decode must freeze; combinational from counters and current inputs.
REQ-014 issue_fire  out  1  issue_valid && !hazard_detected.
REQ-015 busy_mask  out  NUM_REGS  bit r = counter[r] != 0, registered state.
REQ-016 pending_total  out  clog2(NUM_REGS*(2^CNT_W-1))+1 bits  sum of all counters, registered.
REQ-017 underflow_err  out  1  sticky: retire or kill hit a zero counter.

Function
REQ-018 One CNT_W counter per register; the next count is count + inc - dec_r - dec_k, where inc = issue_fire && issue_wb_en && dst match, dec_r = retire_valid && dst match, dec_k = kill_valid && dst match.
REQ-019 hazard_detected SHALL be 1 when has_srcN && counter[srcN] != 0 for either source, except as REQ-020 provides.
REQ-020 With RETIRE_BYPASS=1, a source SHALL NOT raise a hazard when counter[srcN]==1 and retire_valid && retire_dst==srcN in the same cycle.
REQ-021 hazard_detected SHALL also be 1 when issue_valid && issue_wb_en && counter[issue_dst] == max, i.e. saturation stall; a counter never wraps.
REQ-022 When hazard_detected=1, the issue increments no counter; decrements still apply.
REQ-023 Issue, retire and kill to the same register in one cycle SHALL all apply, and the net change SHALL be computed in a single step.
REQ-024 If a decrement would take a counter below 0, the counter SHALL stay 0 and underflow_err SHALL set on the next edge.
REQ-025 retire_valid and kill_valid on different registers in one cycle SHALL both apply.
REQ-026 busy_mask and pending_total SHALL reflect the counters after the edge, with 1-cycle latency from an event to its output.
REQ-027 Register index 0 is not special; all NUM_REGS registers are tracked identically.

Reset
REQ-028 On rst=1 at an edge, all counters, busy_mask, pending_total and underflow_err SHALL become 0; rst overrides every same-cycle issue, retire or kill.
REQ-029 Immediately after reset, hazard_detected SHALL be 0 for any src input.
REQ-030 Reset mid-operation SHALL discard all pending state without generating underflow_err.

Structure
REQ-031 The shared package SHALL hold REG_ADDR_W, the default NUM_REGS, and the counter-max constant.
REQ-032 Per-register counter logic SHALL be one sub-module, sb_counter, instantiated NUM_REGS times via generate; the hazard compare and the pending_total adder tree stay in the top level.

Verification
REQ-033 Issue R3 (wb_en=1), next cycle src1=R3, has_src1=1 -> hazard_detected=1, issue_fire=0; retire R3 with RETIRE_BYPASS=1 -> hazard 0 in that same cycle, busy_mask[3]=0 after the edge.
REQ-034 Issue R5 three times with CNT_W=2 (count 3), then a fourth issue to R5 -> saturation stall, counter stays 3, pending_total=3.
REQ-035 In one cycle, issue R7, retire R7 and kill R7 with counter[7]=2 -> counter[7]=1 after the edge.
REQ-036 Retire R9 with counter[9]=0 -> counter stays 0, underflow_err=1 and stays 1 until rst.
REQ-037 With counters R1=2 and R4=1, assert rst together with issue R1 -> all counters 0, pending_total=0, underflow_err=0.
REQ-038 has_src2=0, src2=R2 busy -> no hazard; RETIRE_BYPASS=0 with count 1 and same-cycle retire -> hazard stays 1 for that cycle.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard: default register count,
// address width and the per-register pending-write counter ceiling.
package reg_scoreboard_pkg;
    localparam int SB_NUM_REGS   = 16;
    localparam int SB_REG_ADDR_W = $clog2(SB_NUM_REGS);
    localparam int SB_CNT_W      = 2;
    localparam int SB_CNT_MAX    = (1 << SB_CNT_W) - 1;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter. Issue, retire and kill are folded into
// one signed net change; results below zero clamp to 0 and flag underflow.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_r,
    input  logic             dec_k,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             underflow
);
    logic signed [CNT_W+1:0] sum;

    always_comb begin
        sum = $signed({2'b00, cnt})
            + $signed({{(CNT_W+1){1'b0}}, inc})
            - $signed({{(CNT_W+1){1'b0}}, dec_r})
            - $signed({{(CNT_W+1){1'b0}}, dec_k});
        underflow = (sum < 0);
        if (underflow)
            cnt_nxt = '0;
        else if (sum[CNT_W])
            cnt_nxt = '1;  // the saturation stall keeps this unreachable; never wrap
        else
            cnt_nxt = sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per architectural register and
// stalls decode on RAW hazards or when a register's pending counter is full.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS      = SB_NUM_REGS,
    parameter int REG_ADDR_W    = SB_REG_ADDR_W,
    parameter int CNT_W         = SB_CNT_W,
    parameter int RETIRE_BYPASS = 1,
    localparam int PT_W         = $clog2(NUM_REGS * ((1 << CNT_W) - 1)) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  has_src1,
    input  logic                  has_src2,
    input  logic                  issue_valid,
    input  logic                  issue_wb_en,
    input  logic [REG_ADDR_W-1:0] issue_dst,
    input  logic                  retire_valid,
    input  logic [REG_ADDR_W-1:0] retire_dst,
    input  logic                  kill_valid,
    input  logic [REG_ADDR_W-1:0] kill_dst,
    output logic                  hazard_detected,
    output logic                  issue_fire,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic [PT_W-1:0]       pending_total,
    output logic                  underflow_err
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt, cnt_nxt;
    logic [NUM_REGS-1:0]            uflow;
    logic                           inc_en, hz1, hz2, sat;
    logic [PT_W-1:0]                tot_nxt;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_en && issue_dst == REG_ADDR_W'(g)),
            .dec_r     (retire_valid && retire_dst == REG_ADDR_W'(g)),
            .dec_k     (kill_valid && kill_dst == REG_ADDR_W'(g)),
            .cnt       (cnt[g]),
            .cnt_nxt   (cnt_nxt[g]),
            .underflow (uflow[g])
        );
    end

    // A last outstanding write retiring this cycle is visible through the
    // write-through register file, so it need not stall the reader.
    always_comb begin
        hz1 = has_src1 && cnt[src1] != '0 &&
              !(RETIRE_BYPASS != 0 && cnt[src1] == ONE && retire_valid && retire_dst == src1);
        hz2 = has_src2 && cnt[src2] != '0 &&
              !(RETIRE_BYPASS != 0 && cnt[src2] == ONE && retire_valid && retire_dst == src2);
        sat = issue_valid && issue_wb_en && cnt[issue_dst] == MAX;
    end

    assign hazard_detected = hz1 || hz2 || sat;
    assign issue_fire      = issue_valid && !hazard_detected;
    assign inc_en          = issue_fire && issue_wb_en;

    always_comb begin
        tot_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) tot_nxt = tot_nxt + PT_W'(cnt_nxt[i]);
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) busy_mask[i] = |cnt[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_total <= '0;
            underflow_err <= 1'b0;
        end else begin
            pending_total <= tot_nxt;
            underflow_err <= underflow_err | (|uflow);
        end
    end
endmodule
